// File: rtl/ff_pkg.sv
// -----------------------------------------------------------------------------
// ff_pkg
// Shared definitions for the GF(p) field arithmetic blocks, p = 2^255 - 19.
//   P          field modulus (256-bit, fully reduced operands are < P)
//   LIMB_W     limb width in bits
//   NLIMBS     limbs per operand
//   OP_W       operand width (LIMB_W * NLIMBS)
//   ff_state_e limb-serial sequencer states (IDLE, SUB0..SUB3, FIX)
//   addsub_mode_e  add/subtract select for the limb arithmetic unit
//   p_limb()   returns limb idx of P
// -----------------------------------------------------------------------------
package ff_pkg;

    localparam int LIMB_W = 64;
    localparam int NLIMBS = 4;
    localparam int OP_W   = LIMB_W * NLIMBS;

    localparam logic [OP_W-1:0] P =
        256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB0 = 3'd1,
        SUB1 = 3'd2,
        SUB2 = 3'd3,
        SUB3 = 3'd4,
        FIX  = 3'd5
    } ff_state_e;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } addsub_mode_e;

    function automatic logic [LIMB_W-1:0] p_limb(input logic [1:0] idx);
        return P[idx*LIMB_W +: LIMB_W];
    endfunction

endpackage

// File: rtl/limb_addsub64.sv
// -----------------------------------------------------------------------------
// limb_addsub64
// Combinational 64-bit limb adder/subtractor with carry/borrow chaining.
//   mode  MODE_ADD: res = x + y + cin,  cout = carry out
//         MODE_SUB: res = x - y - cin,  cout = borrow out
//   x, y  limb operands
//   cin   carry-in (add) or borrow-in (sub)
//   res   low LIMB_W bits of the result
//   cout  carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module limb_addsub64 import ff_pkg::*; (
    input  addsub_mode_e      mode,
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    input  logic              cin,
    output logic [LIMB_W-1:0] res,
    output logic              cout
);

    // One extra bit: for add it holds the carry, for subtract a negative
    // result wraps so the extra bit reads as the borrow.
    logic [LIMB_W:0] wide;

    always_comb begin
        if (mode == MODE_SUB)
            wide = {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, cin};
        else
            wide = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
    end

    assign res  = wide[LIMB_W-1:0];
    assign cout = wide[LIMB_W];

endmodule

// File: rtl/ffsub.sv
// -----------------------------------------------------------------------------
// ffsub
// Multi-cycle modular subtractor over GF(2^255 - 19): out = (a - b) mod p.
// Limbs are processed LSB-first. The subtract stage produces d[i] while the
// add stage, one limb behind, produces f[i-1] = d[i-1] + P[i-1], so the
// add-back of p overlaps the raw difference. FIX selects f when the overall
// subtraction borrowed, d otherwise.
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous, active-high reset
//   start  operation request, sampled only in IDLE
//   a, b   fully reduced operands (< p)
//   out    registered result, held until the next done
//   done   one-cycle completion pulse
//   busy   high while an operation is in flight (falls as done rises)
//
// Build option
//   FFSUB_INPUT_LATCH_EN  defined: a/b are registered at the accepting edge
//                         and may change afterwards.
//                         undefined: a/b are read limb by limb and must be
//                         held stable from start until done.
// -----------------------------------------------------------------------------
module ffsub import ff_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] out,
    output logic            done,
    output logic            busy
);

    ff_state_e         state;
    logic [LIMB_W-1:0] d [NLIMBS];
    logic [LIMB_W-1:0] f [NLIMBS];
    logic              borrow;
    logic              carry;

    logic [OP_W-1:0]   a_src;
    logic [OP_W-1:0]   b_src;

`ifdef FFSUB_INPUT_LATCH_EN
    logic [OP_W-1:0]   a_r;
    logic [OP_W-1:0]   b_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
        end else if (state == IDLE && start) begin
            a_r <= a;
            b_r <= b;
        end
    end

    assign a_src = a_r;
    assign b_src = b_r;
`else
    assign a_src = a;
    assign b_src = b;
`endif

    // Limb indices: the subtract stage works on limb sub_idx, the add stage
    // trails it by one limb (and finishes limb 3 in FIX).
    logic [1:0] sub_idx;
    logic [1:0] add_idx;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sub_idx = 2'd0;
        add_idx = 2'd0;
        case (state)
            SUB1: begin sub_idx = 2'd1; add_idx = 2'd0; end
            SUB2: begin sub_idx = 2'd2; add_idx = 2'd1; end
            SUB3: begin sub_idx = 2'd3; add_idx = 2'd2; end
            FIX:  begin sub_idx = 2'd0; add_idx = 2'd3; end
            default: ;
        endcase
    end

    logic [LIMB_W-1:0] diff;
    logic              diff_borrow;
    logic [LIMB_W-1:0] fsum;
    logic              fsum_carry;

    limb_addsub64 u_sub (
        .mode (MODE_SUB),
        .x    (a_src[sub_idx*LIMB_W +: LIMB_W]),
        .y    (b_src[sub_idx*LIMB_W +: LIMB_W]),
        .cin  (borrow),
        .res  (diff),
        .cout (diff_borrow)
    );

    limb_addsub64 u_add (
        .mode (MODE_ADD),
        .x    (d[add_idx]),
        .y    (p_limb(add_idx)),
        .cin  (carry),
        .res  (fsum),
        .cout (fsum_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            borrow <= 1'b0;
            carry  <= 1'b0;
            out    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            // NOTE: the limb arrays are small register banks, not RAM, and a
            // mid-operation reset must leave no stale partial result, so they
            // are cleared with everything else.
            for (int i = 0; i < NLIMBS; i++) begin
                d[i] <= '0;
                f[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SUB0;
                        borrow <= 1'b0;
                        carry  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                SUB0: begin
                    d[sub_idx] <= diff;
                    borrow     <= diff_borrow;
                    state      <= SUB1;
                end
                SUB1, SUB2, SUB3: begin
                    d[sub_idx] <= diff;
                    borrow     <= diff_borrow;
                    f[add_idx] <= fsum;
                    carry      <= fsum_carry;
                    state      <= ff_state_e'(state + 3'd1);
                end
                FIX: begin
                    // Carry out of the top limb is discarded: a - b + p < p
                    // whenever the subtraction borrowed.
                    f[add_idx] <= fsum;
                    out        <= borrow ? {fsum, f[2], f[1], f[0]}
                                         : {d[3], d[2], d[1], d[0]};
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffsub.sv
// -----------------------------------------------------------------------------
// tb_ffsub
// Self-checking bench for ffsub: directed vector table with hand-derived
// results, a mid-operation asynchronous reset, and a back-to-back run of
// random field elements against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_ffsub;

    localparam logic [255:0] P_TB =
        256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] a_in;
    logic [255:0] b_in;
    logic [255:0] out;
    logic         done;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ffsub dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: (a - b) mod p with plain wide arithmetic.
    function automatic logic [255:0] ref_sub(input logic [255:0] x,
                                             input logic [255:0] y);
        logic [256:0] t;
        if (x >= y) t = {1'b0, x} - {1'b0, y};
        else        t = {1'b0, x} + {1'b0, P_TB} - {1'b0, y};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        if ($urandom_range(0, 3) == 0)
            return P_TB - 256'($urandom_range(1, 40));
        do begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            v[255] = 1'b0;
        end while (v >= P_TB);
        return v;
    endfunction

    // One operation with full timing checks: latency 5 edges from the
    // accepting edge, busy high for 5 samples, done for a single cycle.
    task automatic run_op(input string name, input logic [255:0] a,
                          input logic [255:0] b, input logic [255:0] exp);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        check({name, " latency"}, 256'(cyc), 256'd5);
        check({name, " busy_cycles"}, 256'(busy_cnt), 256'd5);
        check({name, " result"}, out, exp);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, 256'(done), 256'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        int           cyc;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        vecs.push_back('{"5-3",       256'd5, 256'd3, 256'd2});
        vecs.push_back('{"3-5",       256'd3, 256'd5, P_TB - 256'd2});
        vecs.push_back('{"0-1",       256'd0, 256'd1, P_TB - 256'd1});
        vecs.push_back('{"pm1-pm1",   P_TB - 256'd1, P_TB - 256'd1, 256'd0});
        vecs.push_back('{"2^64-1",    256'd1 << 64, 256'd1,
                         256'h0000000000000000_0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF});
        vecs.push_back('{"2^192-1",   256'd1 << 192, 256'd1,
                         256'h0000000000000000_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF});
        vecs.push_back('{"0-pm1",     256'd0, P_TB - 256'd1, 256'd1});
        vecs.push_back('{"pm1-0",     P_TB - 256'd1, 256'd0, P_TB - 256'd1});

        #12;
        check("reset out",  out, 256'd0);
        check("reset done", 256'(done), 256'd0);
        check("reset busy", 256'(busy), 256'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Asynchronous reset while the sequencer is in SUB2.
        @(negedge clk);
        a_in  = 256'd9;
        b_in  = 256'd4;
        start = 1'b1;
        @(posedge clk);          // accept -> SUB0
        #1 start = 1'b0;
        @(posedge clk);          // -> SUB1
        @(posedge clk);          // -> SUB2
        #2 rst = 1'b1;
        #1;
        check("midrst out",  out, 256'd0);
        check("midrst done", 256'(done), 256'd0);
        check("midrst busy", 256'(busy), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst 7-2", 256'd7, 256'd2, 256'd5);

        // Back-to-back with start held high: one result every 6 cycles.
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            ra   = rand_fe();
            rb   = rand_fe();
            a_in = ra;
            b_in = rb;
            @(posedge clk);
            #1;
            cyc = 1;
            check("b2b accepted", 256'(busy), 256'd1);
`ifdef FFSUB_INPUT_LATCH_EN
            a_in = rand_fe();
            b_in = rand_fe();
`endif
            while (!done && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("b2b spacing", 256'(cyc), 256'd6);
            check("b2b result", out, ref_sub(ra, rb));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("idle done", 256'(done), 256'd0);
        check("idle busy", 256'(busy), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
